// File: rtl/fp_alu_pkg.sv
// Shared floating-point ALU definitions: field widths, common IEEE-754 constants
// and the issue-entry layout {a, b, op, tag} used by the queue.
package fp_alu_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_INF = 32'h7F80_0000;

    // Operand part of an issue entry; the tag is appended by the user since its width is a parameter.
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            op;
    } issue_ops_t;

    function automatic int issue_entry_w(input int tag_w);
        return 2 * FP_W + 1 + tag_w;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO with push/pop, full/empty flags and an entry count
// carrying one extra bit so that full and empty are distinct.
module fp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fp_addsub_issue_queue.sv
// Clocked wrapper around the combinational FP add/sub unit: FIFO -> issue register -> result register.
// Optional macro FP_ISSUE_STATS_EN adds op_count / exc_count delivery statistics.
module fp_addsub_issue_queue
    import fp_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FP_W-1:0]          in_a_operand,
    input  logic [FP_W-1:0]          in_b_operand,
    input  logic                     in_AddBar_Sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [FP_W-1:0]          a_operand,
    output logic [FP_W-1:0]          b_operand,
    output logic                     AddBar_Sub,
    input  logic [FP_W-1:0]          result,
    input  logic                     Exception,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP_W-1:0]          out_result,
    output logic                     out_exception,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     sticky_exception,
    input  logic                     clear_sticky,
`ifdef FP_ISSUE_STATS_EN
    output logic [31:0]              op_count,
    output logic [15:0]              exc_count,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int ENTRY_W = issue_entry_w(TAG_W);

    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    issue_ops_t         head_ops;
    logic [TAG_W-1:0]   head_tag;

    logic               push;
    logic               pop;
    logic               is_adv;
    logic               rs_adv;
    logic               delivered;

    logic               vld_p1;
    logic [FP_W-1:0]    a_p1;
    logic [FP_W-1:0]    b_p1;
    logic               op_p1;
    logic [TAG_W-1:0]   tag_p1;

    logic               vld_p2;
    logic [FP_W-1:0]    result_p2;
    logic               exc_p2;
    logic [TAG_W-1:0]   tag_p2;

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign rs_adv    = !vld_p2 || out_ready;
    assign is_adv    = vld_p1 && rs_adv;
    assign pop       = !fifo_empty && (!vld_p1 || is_adv);
    assign delivered = vld_p2 && out_ready;

    assign {head_ops, head_tag} = fifo_rdata;

    fp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({in_a_operand, in_b_operand, in_AddBar_Sub, in_tag}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // Stage p1: issue register feeding the adder; holds its value when idle or stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= 1'b0;
            tag_p1 <= '0;
        end else if (pop) begin
            vld_p1 <= 1'b1;
            a_p1   <= head_ops.a;
            b_p1   <= head_ops.b;
            op_p1  <= head_ops.op;
            tag_p1 <= head_tag;
        end else if (is_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    assign a_operand  = a_p1;
    assign b_operand  = b_p1;
    assign AddBar_Sub = op_p1;

    // Stage p2: result register captures the adder output alongside the issue tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            exc_p2    <= 1'b0;
            tag_p2    <= '0;
        end else if (is_adv) begin
            vld_p2    <= 1'b1;
            result_p2 <= result;
            exc_p2    <= Exception;
            tag_p2    <= tag_p1;
        end else if (out_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign out_valid     = vld_p2;
    assign out_result    = result_p2;
    assign out_exception = exc_p2;
    assign out_tag       = tag_p2;

    // A delivered exception outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_exception <= 1'b0;
        end else if (delivered && exc_p2) begin
            sticky_exception <= 1'b1;
        end else if (clear_sticky) begin
            sticky_exception <= 1'b0;
        end
    end

`ifdef FP_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count  <= '0;
            exc_count <= '0;
        end else if (delivered) begin
            op_count <= op_count + 1'b1;
            if (exc_p2 && (exc_count != 16'hFFFF)) exc_count <= exc_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_addsub_issue_queue.sv
// Directed bench for fp_addsub_issue_queue with a behavioural stand-in for the external adder.
module tb_fp_addsub_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a_operand;
    logic [31:0] in_b_operand;
    logic        in_AddBar_Sub;
    logic [3:0]  in_tag;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        AddBar_Sub;
    logic [31:0] result;
    logic        Exception;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_exception;
    logic [3:0]  out_tag;
    logic        sticky_exception;
    logic        clear_sticky;
    logic [2:0]  occupancy;
`ifdef FP_ISSUE_STATS_EN
    logic [31:0] op_count;
    logic [15:0] exc_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_addsub_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a_operand     (in_a_operand),
        .in_b_operand     (in_b_operand),
        .in_AddBar_Sub    (in_AddBar_Sub),
        .in_tag           (in_tag),
        .a_operand        (a_operand),
        .b_operand        (b_operand),
        .AddBar_Sub       (AddBar_Sub),
        .result           (result),
        .Exception        (Exception),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_exception    (out_exception),
        .out_tag          (out_tag),
        .sticky_exception (sticky_exception),
        .clear_sticky     (clear_sticky),
`ifdef FP_ISSUE_STATS_EN
        .op_count         (op_count),
        .exc_count        (exc_count),
`endif
        .occupancy        (occupancy)
    );

    // Single-precision <-> double conversion for normal numbers and zero only.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) begin
            d = {f[31], 63'd0};
        end else begin
            e = {3'b000, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Adder stand-in: any operand with an all-ones exponent raises Exception and yields 0.
    function automatic logic [32:0] adder_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real ra;
        real rb;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'd0};
        ra = f2r(a);
        rb = f2r(b);
        return {1'b0, r2f(sub ? (ra - rb) : (ra + rb))};
    endfunction

    always_comb begin
        {Exception, result} = adder_model(a_operand, b_operand, AddBar_Sub);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag);
        in_valid      = 1'b1;
        in_a_operand  = a;
        in_b_operand  = b;
        in_AddBar_Sub = op;
        in_tag        = tag;
    endtask

    task automatic single_add(input string pfx);
        drive(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
        tick();
        in_valid = 1'b0;
        check({pfx, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({pfx, "_lat2_valid"}, {31'd0, out_valid}, 32'd0);
        check({pfx, "_is_a"}, a_operand, 32'h3F800000);
        check({pfx, "_is_b"}, b_operand, 32'h40000000);
        tick();
        check({pfx, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({pfx, "_result"}, out_result, 32'h40400000);
        check({pfx, "_tag"}, {28'd0, out_tag}, 32'd1);
        check({pfx, "_exc"}, {31'd0, out_exception}, 32'd0);
        tick();
        check({pfx, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_a_operand  = 32'd0;
        in_b_operand  = 32'd0;
        in_AddBar_Sub = 1'b0;
        in_tag        = 4'd0;
        out_ready     = 1'b1;
        clear_sticky  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_a_operand", a_operand, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_sticky", {31'd0, sticky_exception}, 32'd0);

        single_add("add");

        // Back-to-back: 3.0 - 1.0 then 1.0 + 1.0
        drive(32'h40400000, 32'h3F800000, 1'b1, 4'd2);
        tick();
        drive(32'h3F800000, 32'h3F800000, 1'b0, 4'd3);
        tick();
        in_valid = 1'b0;
        tick();
        check("b2b_valid0", {31'd0, out_valid}, 32'd1);
        check("b2b_result0", out_result, 32'h40000000);
        check("b2b_tag0", {28'd0, out_tag}, 32'd2);
        tick();
        check("b2b_valid1", {31'd0, out_valid}, 32'd1);
        check("b2b_result1", out_result, 32'h40000000);
        check("b2b_tag1", {28'd0, out_tag}, 32'd3);
        tick();
        check("b2b_empty", {31'd0, out_valid}, 32'd0);

        // Exception and sticky flag
        drive(32'h7F800000, 32'h3F800000, 1'b0, 4'd4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("exc_valid", {31'd0, out_valid}, 32'd1);
        check("exc_result", out_result, 32'd0);
        check("exc_flag", {31'd0, out_exception}, 32'd1);
        check("exc_sticky_pre", {31'd0, sticky_exception}, 32'd0);
        tick();
        check("exc_sticky_set", {31'd0, sticky_exception}, 32'd1);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check("exc_sticky_clr", {31'd0, sticky_exception}, 32'd0);

        // Back-pressure: fill RS, IS and the FIFO with out_ready low
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h3F800000, 32'h3F800000, 1'b0, accepted[3:0]);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 32'd6);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_occupancy", {29'd0, occupancy}, 32'd4);
        check("bp_head_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_tag", {28'd0, out_tag}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_occ_after_pop", {29'd0, occupancy}, 32'd3);
        for (int k = 1; k < 6; k++) begin
            check($sformatf("bp_order_valid%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_order_tag%0d", k), {28'd0, out_tag}, k);
            tick();
        end
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        check("bp_result", out_result, 32'h40000000);

        // Simultaneous push/pop at occupancy 2, with pointers well past a wrap
        out_ready = 1'b0;
        for (int t = 8; t < 12; t++) begin
            drive(32'h3F800000, 32'h40000000, 1'b0, t[3:0]);
            tick();
        end
        check("pp_occ_setup", {29'd0, occupancy}, 32'd2);
        check("pp_head_tag", {28'd0, out_tag}, 32'd8);
        drive(32'h3F800000, 32'h40000000, 1'b0, 4'd12);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_occ_same", {29'd0, occupancy}, 32'd2);
        for (int t = 9; t < 13; t++) begin
            check($sformatf("pp_order_tag%0d", t), {28'd0, out_tag}, t);
            tick();
        end
        check("pp_drained", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            drive(32'h40400000, 32'h3F800000, 1'b1, t[3:0]);
            tick();
        end
        in_valid = 1'b0;
        check("mr_occ_setup", {29'd0, occupancy}, 32'd3);
        check("mr_valid_setup", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_occupancy", {29'd0, occupancy}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_sticky", {31'd0, sticky_exception}, 32'd0);
        check("mr_out_tag", {28'd0, out_tag}, 32'd0);
        check("mr_a_operand", a_operand, 32'd0);
        single_add("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
